dm_store_unit: RTL

- Write-side companion of the data-memory load extender.
- Accepts sw/sb/sh store requests from the MEM stage and drives a word-wide synchronous data memory that has no byte enables.
- Full-word stores are written directly.
- Byte and halfword stores use read-modify-write: read the word, merge the sub-word lane, write back.
- Misaligned or reserved requests are rejected with an error pulse and no memory access.

---
 rtl/dm_store_unit.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dm_store_unit.sv
// dm_store_unit: write-side companion of the data-memory load extender.
// Accepts sw/sb/sh store requests and drives a word-wide synchronous memory
// that has no byte enables. Full-word stores are written directly. Byte and
// halfword stores read the word, merge the target lane and write it back.
// Misaligned or reserved requests raise a one-cycle misalign_err pulse and
// never touch the memory.
//
// Optional build macro DM_STORE_FWD_EN: keeps a copy of the last written word
// so that a sub-word store to that same word skips the read and merge steps.
//
// Handshake: a request is consumed on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE. A requester that
// sees req_ready low must hold req_valid and its payload stable until the
// request is consumed.
module dm_store_unit #(
    parameter int WA_W = 30
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    output logic [WA_W-1:0] mem_addr,
    output logic            mem_rd_en,
    input  logic [31:0]     mem_rdata,
    output logic            mem_wr_en,
    output logic [31:0]     mem_wdata,
    output logic            busy,
    output logic            misalign_err
);

    localparam logic [1:0] OP_SW = 2'b00;
    localparam logic [1:0] OP_SB = 2'b01;
    localparam logic [1:0] OP_SH = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        MERGE = 2'b10,
        WRITE = 2'b11
    } state_t;

    state_t          state;
    logic [1:0]      op_q;
    logic [1:0]      lane_q;
    logic [31:0]     wdata_q;

    logic            req_legal;
    logic [WA_W-1:0] req_word;
    logic            fwd_hit;
    logic [31:0]     fwd_base;

    assign req_word  = req_addr[WA_W+1:2];
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Replace only the addressed byte/halfword lane of base with store data.
    function automatic logic [31:0] merge_lane(
        input logic [31:0] base,
        input logic [1:0]  op,
        input logic [1:0]  lane,
        input logic [31:0] wdata
    );
        logic [31:0] merged;
        merged = base;
        if (op == OP_SB) begin
            case (lane)
                2'd0:    merged[7:0]   = wdata[7:0];
                2'd1:    merged[15:8]  = wdata[7:0];
                2'd2:    merged[23:16] = wdata[7:0];
                default: merged[31:24] = wdata[7:0];
            endcase
        end else if (op == OP_SH) begin
            if (lane[1]) merged[31:16] = wdata[15:0];
            else         merged[15:0]  = wdata[15:0];
        end
        return merged;
    endfunction

    // Alignment rules: sw word-aligned, sh halfword-aligned, sb any, op 11 never.
    always_comb begin
        req_legal = 1'b0;
        case (req_op)
            OP_SW:   req_legal = (req_addr[1:0] == 2'b00);
            OP_SB:   req_legal = 1'b1;
            OP_SH:   req_legal = (req_addr[0] == 1'b0);
            default: req_legal = 1'b0;
        endcase
    end

`ifdef DM_STORE_FWD_EN
    logic [WA_W-1:0] held_addr;
    logic [31:0]     held_data;
    logic            held_valid;

    // Remember the last word written; this unit is the only memory writer,
    // so the copy always matches the memory contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_valid <= 1'b0;
            held_addr  <= '0;
            held_data  <= 32'h0;
        end else if (mem_wr_en) begin
            held_valid <= 1'b1;
            held_addr  <= mem_addr;
            held_data  <= mem_wdata;
        end
    end

    assign fwd_hit  = held_valid && (held_addr == req_word) && (req_op != OP_SW);
    assign fwd_base = held_data;
`else
    assign fwd_hit  = 1'b0;
    assign fwd_base = 32'h0;
`endif

    // Store sequencer: IDLE -> (READ -> MERGE ->) WRITE -> IDLE, strobes registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            op_q         <= 2'b00;
            lane_q       <= 2'b00;
            wdata_q      <= 32'h0;
            mem_addr     <= '0;
            mem_wdata    <= 32'h0;
            mem_rd_en    <= 1'b0;
            mem_wr_en    <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            mem_rd_en    <= 1'b0;
            mem_wr_en    <= 1'b0;
            misalign_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!req_legal) begin
                            misalign_err <= 1'b1;
                        end else begin
                            mem_addr <= req_word;
                            op_q     <= req_op;
                            lane_q   <= req_addr[1:0];
                            wdata_q  <= req_wdata;
                            if (req_op == OP_SW) begin
                                mem_wdata <= req_wdata;
                                mem_wr_en <= 1'b1;
                                state     <= WRITE;
                            end else if (fwd_hit) begin
                                mem_wdata <= merge_lane(fwd_base, req_op, req_addr[1:0], req_wdata);
                                mem_wr_en <= 1'b1;
                                state     <= WRITE;
                            end else begin
                                mem_rd_en <= 1'b1;
                                state     <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    // Memory returns the word during the MERGE cycle.
                    state <= MERGE;
                end
                MERGE: begin
                    mem_wdata <= merge_lane(mem_rdata, op_q, lane_q, wdata_q);
                    mem_wr_en <= 1'b1;
                    state     <= WRITE;
                end
                WRITE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
